// File: rtl/ds_dac_pkg.sv
// Shared types and constants for the delta-sigma DAC front end.
// Holds the interpolator FSM state type and the midscale helper.
package ds_dac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STARVED
  } interp_state_t;

  localparam int INTERP_LOG2_MIN = 0;
  localparam int INTERP_LOG2_MAX = 4;

  // Midscale code of an unsigned offset-binary value of the given width.
  function automatic logic [31:0] midscale(input int width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/interp_input_buffer.sv
// One-entry input buffer with same-cycle bypass; sample_avail is combinational.
// in_ready is low while the entry is held and rises the cycle after pop.
module interp_input_buffer #(
  parameter int IN_BITS = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [IN_BITS-1:0] in_sample,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               pop,
  output logic               sample_avail,
  output logic [IN_BITS-1:0] sample
);

  logic [IN_BITS-1:0] p;
  logic               p_v;

  assign in_ready     = !p_v;
  // in_valid can only transfer while the entry is empty, so it alone marks a bypass.
  assign sample_avail = p_v || in_valid;
  assign sample       = p_v ? p : in_sample;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p   <= '0;
      p_v <= 1'b0;
    end else if (p_v) begin
      if (pop) p_v <= 1'b0;
    end else if (in_valid && !pop) begin
      p   <= in_sample;
      p_v <= 1'b1;
    end
  end

endmodule

// File: rtl/sample_interpolator.sv
// Linear (SAMPLE_INTERP_LINEAR_EN) or zero-order-hold upsampler feeding the modulator u input.
// u_out updates the cycle after u_take; underrun pulses one cycle after a wrap with no sample.
module sample_interpolator
  import ds_dac_pkg::*;
#(
  parameter int IN_BITS     = 16,
  parameter int INTERP_LOG2 = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [IN_BITS-1:0] in_sample,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               u_take,
  output logic [IN_BITS-1:0] u_out,
  output logic               underrun
);

  localparam int ACC_W = IN_BITS + INTERP_LOG2;
  localparam int PH_W  = (INTERP_LOG2 > 0) ? INTERP_LOG2 : 1;
  localparam logic [PH_W-1:0]    PH_MAX  = PH_W'((1 << INTERP_LOG2) - 1);
  localparam logic [IN_BITS-1:0] MID     = IN_BITS'(midscale(IN_BITS));
  localparam logic [ACC_W-1:0]   ACC_MID = ACC_W'(MID) << INTERP_LOG2;

  logic [IN_BITS-1:0]      b;
  logic [PH_W-1:0]         phase;
  logic [ACC_W-1:0]        acc;
  logic signed [IN_BITS:0] step;
  logic signed [IN_BITS:0] step_next;
  interp_state_t           state_q, state_d;
  logic                    underrun_d;

  logic               wrap;
  logic               pop;
  logic               sample_avail;
  logic [IN_BITS-1:0] sample;

  assign wrap = (phase == PH_MAX);
  assign pop  = u_take && wrap;

  interp_input_buffer #(.IN_BITS(IN_BITS)) u_buf (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_sample    (in_sample),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pop          (pop),
    .sample_avail (sample_avail),
    .sample       (sample)
  );

`ifdef SAMPLE_INTERP_LINEAR_EN
  assign step_next = $signed({1'b0, sample}) - $signed({1'b0, b});
`else
  assign step_next = '0;
`endif

  // The segment start lives in acc at phase 0, so only the end point B is kept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      b     <= MID;
      phase <= '0;
      acc   <= ACC_MID;
      step  <= '0;
    end else if (u_take) begin
      if (wrap) begin
        phase <= '0;
        acc   <= ACC_W'(b) << INTERP_LOG2;
        if (sample_avail) begin
          b    <= sample;
          step <= step_next;
        end else begin
          step <= '0;
        end
      end else begin
        phase <= phase + PH_W'(1);
        acc   <= acc + ACC_W'(step);
      end
    end
  end

  assign u_out = acc[ACC_W-1 -: IN_BITS];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      underrun <= 1'b0;
    end else begin
      state_q  <= state_d;
      underrun <= underrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    underrun_d = 1'b0;
    if (pop) begin
      case (state_q)
        IDLE:    if (sample_avail) state_d = RUN;
        RUN: begin
          if (!sample_avail) begin
            state_d    = STARVED;
            underrun_d = 1'b1;
          end
        end
        STARVED: if (sample_avail) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: doc/sample_interpolator.md
# sample_interpolator

Upstream feeder for the delta-sigma modulator. Accepts input samples over a valid/ready handshake at the audio rate and produces the `u` value the modulator reads once per modulator sample, via a take strobe. Between consecutive input samples it linearly interpolates over 2^INTERP_LOG2 modulator samples, raising the effective input rate and reducing images before noise shaping. It includes a one-entry input buffer and underrun handling.

## Interface
- IN_BITS, 16, sample width, unsigned offset binary (midscale = 2^(IN_BITS-1))
- INTERP_LOG2, 2, log2 of modulator samples per input sample; legal 0..4
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- in_sample  in  IN_BITS  input sample
- in_valid  in  1  in_sample valid
- in_ready  out  1  buffer can accept; transfer when in_valid && in_ready
- u_take  in  1  modulator consumed u_out this cycle; driven by the modulator's y_valid && en
- u_out  out  IN_BITS  value presented to the modulator's u input; registered
- underrun  out  1  one-cycle pulse on entry to STARVED

## Operation
- Registers:
  - A (segment start) and B (segment end), both IN_BITS.
  - P, a pending input buffer, plus its valid flag P_v.
  - phase, INTERP_LOG2 bits.
  - acc, IN_BITS+INTERP_LOG2 bits, unsigned.
  - step, signed IN_BITS+1 bits, equal to B−A.
  - state ∈ {IDLE, RUN, STARVED}.
- in_ready = !P_v. An accepted sample is written to P and sets P_v, unless bypassed (see below).
- u_out = acc[IN_BITS+INTERP_LOG2-1:INTERP_LOG2]. This truncates the fraction. acc always lies between A·2^L and B·2^L, so it cannot overflow.
- Each u_take:
  - Non-wrap (phase ≠ 2^L−1): phase += 1 and acc += step (sign-extended).
  - Wrap (phase = 2^L−1): phase ← 0, A ← B, acc ← B·2^L. If a sample is available, B ← that sample and step ← sample − old B. If no sample is available, B unchanged and step ← 0.
- A sample is available at wrap if P_v = 1, or if an in_valid transfer happens in the same cycle (bypass).
  - With P_v set, P is consumed and P_v cleared.
  - On a same-cycle transfer with P empty, in_sample goes straight to B and P stays empty.
  - If P_v and a transfer would coincide, it cannot happen, because in_ready = 0 while P_v = 1.
- FSM (evaluated at wrap only):
  - IDLE: no sample yet. Wrap with a sample → RUN. Wrap without one stays IDLE, with no underrun.
  - RUN: wrap with a sample → RUN. Wrap without one → STARVED, and underrun pulses the next cycle.
  - STARVED: u_out holds B. Wrap with a sample → RUN. Wrap without one stays STARVED, with no further pulse.
- With INTERP_LOG2 = 0, every take is a wrap and u_out equals the latest sample, one take late.

## Timing
- Reset values:
  - A = B = midscale; acc = midscale·2^L; u_out = midscale.
  - phase = 0; step = 0; P_v = 0.
  - in_ready = 1; underrun = 0; state = IDLE.
- Reset mid-operation discards P and the current segment; the buffer is empty the next cycle.
- u_out updates the cycle after u_take.
- u_take may be high on consecutive cycles; each high cycle is one take.
- Latency: an accepted sample becomes B at the next wrap. u_out reaches it exactly 2^L takes later.
- underrun is registered: high for exactly one cycle, the cycle after the failing wrap.
- in_ready rises the cycle after P is consumed.

## Configuration
- SAMPLE_INTERP_LINEAR_EN defined: linear interpolation as above.
- SAMPLE_INTERP_LINEAR_EN undefined: zero-order hold.
  - step is forced to 0 and the step subtractor is omitted.
  - u_out = A and changes only at wrap, so each sample is held for 2^L takes.
  - Handshake, FSM and underrun behave identically.

## Structure
- Package ds_dac_pkg holds:
  - typedef enum interp_state_t {IDLE, RUN, STARVED}.
  - A function giving midscale for a width.
  - The INTERP_LOG2 legal-range constant.
- Sub-module interp_input_buffer: the one-entry P/P_v buffer with bypass. Its ports are in_sample/in_valid/in_ready, a pop strobe, and a sample_avail/sample output.

## Test plan
All scenarios use IN_BITS=16, INTERP_LOG2=2.
- Reset: hold reset_n=0 for 2 cycles → u_out=0x8000, in_ready=1, underrun=0. A reset asserted mid-ramp gives the same values next cycle.
- Ramp up: push 0x9000 and 0x9000, then 8 single takes → u_out sequence 0x8000×3, then 0x8000, 0x8400, 0x8800, 0x8C00, 0x9000.
- Ramp down: with A=0x9000, push 0x8000 → successive u_out values 0x9000, 0x8C00, 0x8800, 0x8400, 0x8000.
- Underrun: in RUN, give no sample at wrap → underrun pulses 1 cycle and u_out holds 0x9000 for 4 takes. Then push 0xA000 → next segment ramps by 0x0400 per take.
- Bypass and backpressure:
  - in_valid pulsed on the wrap cycle with P empty → no underrun and B=in_sample.
  - With P full, in_ready=0 and the held sample is accepted only after the wrap.
- Macro off: same stimulus as the ramp-up case → u_out=0x8000 for 8 takes, then 0x9000.
